mips_alu: RTL and testbench
===========================

Name: mips_alu

Overview:
Single-cycle-issue arithmetic/logic unit for the MIPS-style datapath. It decodes OPCODE/FUNC and computes RESULT from the register operands, shift amount and 16-bit immediate. It also raises SIG_B when a branch condition holds. Outputs are registered, so it sits between the decode stage and the execute/branch-resolve stage with a fixed one-cycle latency.

Parameters:
WIDTH, 32, datapath width of RS_VAL, RT_VAL and RESULT. Only 32 is required to be supported.

Ports:
CLK  input  1  rising-edge clock
RST_N  input  1  asynchronous active-low reset
OPCODE  input  6  instruction opcode field
RS_VAL  input  32  rs operand value
RT_VAL  input  32  rt operand value
SHAMT  input  5  shift amount field
FUNC  input  6  R-type function field
RAW_VAL  input  16  raw immediate field
RESULT  output  32  registered ALU result
SIG_B  output  1  registered branch-taken flag

Behaviour:
- Clock and reset: one clock, CLK. Reset RST_N is asynchronous and active-low.
  - While RST_N=0: RESULT=0 and SIG_B=0, immediately and regardless of CLK.
  - First capture after release is on the next rising CLK edge.
- Latency: inputs are sampled on the rising CLK edge; RESULT and SIG_B reflect that sample until the next edge.
  - No handshake; a new operation is accepted every cycle.
- Immediate extension:
  - SEXT = RAW_VAL sign-extended to 32 bits.
  - ZEXT = RAW_VAL zero-extended to 32 bits.
- R-type, OPCODE=000000, decoded by FUNC:
  - 100000 add, 100001 addu: RS+RT.
  - 100010 sub, 100011 subu: RS-RT.
  - 100100 and, 100101 or, 100110 xor, 100111 nor.
  - 101010 slt: signed RS<RT gives 1, else 0.
  - 101011 sltu: unsigned compare, same encoding.
  - 000000 sll, 000010 srl, 000011 sra: RT shifted by SHAMT (sra is arithmetic).
  - 000100 sllv, 000110 srlv, 000111 srav: RT shifted by RS[4:0].
  - Any other FUNC: RESULT=0.
  - SIG_B=0 for all R-type operations.
- I-type:
  - 001000 addi, 001001 addiu: RS+SEXT.
  - 001010 slti: signed RS<SEXT. 001011 sltiu: unsigned RS<SEXT.
  - 001100 andi, 001101 ori, 001110 xori: RS op ZEXT.
  - 001111 lui: {RAW_VAL,16'h0000}.
  - 100011 lw, 101011 sw: RS+SEXT (effective address).
  - SIG_B=0 for all of these.
- Branches: RESULT=RS-RT (wrapping) for all four.
  - 000100 beq: SIG_B = (RS_VAL==RT_VAL).
  - 000101 bne: SIG_B = (RS_VAL!=RT_VAL).
  - 000110 blez: SIG_B = signed RS_VAL<=0.
  - 000111 bgtz: SIG_B = signed RS_VAL>0.
- Unrecognised OPCODE: RESULT=0, SIG_B=0.
- Arithmetic rules:
  - All add/sub results are modulo 2^32.
  - No overflow trap or flag, including for add/sub/addi.
  - Shifts use only 5 bits of shift amount.

Test Plan:
- Reset: assert RST_N=0 mid-operation with prior RESULT nonzero -> RESULT=0 and SIG_B=0 without a clock edge; release and apply add -> valid result after 1 edge.
- BNE: OPCODE=000101, RS=15, RT=12 -> SIG_B=1; RS=15, RT=15 -> SIG_B=0; RS=5, RT=15 -> SIG_B=1. Each result appears one cycle after apply.
- BEQ/BLEZ/BGTZ:
  - beq with RS=RT=7 -> SIG_B=1.
  - blez with RS=32'hFFFFFFFF -> SIG_B=1.
  - bgtz with RS=0 -> SIG_B=0.
- Arithmetic wrap:
  - add RS=32'hFFFFFFFF, RT=1 -> RESULT=0.
  - sub RS=5, RT=15 -> RESULT=32'hFFFFFFF6.
  - slt gives 1, sltu gives 0 for the same operands.
- Shifts:
  - sra RT=32'h80000000, SHAMT=4 -> 32'hF8000000.
  - srl same operands -> 32'h08000000.
  - sllv RT=1, RS=33 -> 2.
- Immediates:
  - addi RS=10, RAW=16'hFFFF -> 9.
  - ori RS=0, RAW=16'hFFFF -> 32'h0000FFFF.
  - lui RAW=16'h1234 -> 32'h12340000.
  - Unknown OPCODE 111111 -> RESULT=0, SIG_B=0.

Source files
------------

// File: rtl/mips_alu_if.sv
// mips_alu_if
//   Groups the operand/decode bus feeding the ALU and the registered
//   result bus coming back out.
//
//   Ports (signals):
//     OPCODE  [5:0]       instruction opcode field
//     RS_VAL  [WIDTH-1:0] rs operand value
//     RT_VAL  [WIDTH-1:0] rt operand value
//     SHAMT   [4:0]       shift amount field
//     FUNC    [5:0]       R-type function field
//     RAW_VAL [15:0]      raw immediate field
//     RESULT  [WIDTH-1:0] registered ALU result
//     SIG_B               registered branch-taken flag
//
//   Modports:
//     master - the decode stage: drives operands, observes results
//     slave  - the ALU: consumes operands, drives results
//
//   Handshake: none. There is no valid/ready pair; the ALU samples the
//   operand bus on every rising clock edge and RESULT/SIG_B always show
//   the outcome of the most recent sample (one cycle of latency).
interface mips_alu_if #(
    parameter int WIDTH = 32
);
    logic [5:0]       OPCODE;
    logic [WIDTH-1:0] RS_VAL;
    logic [WIDTH-1:0] RT_VAL;
    logic [4:0]       SHAMT;
    logic [5:0]       FUNC;
    logic [15:0]      RAW_VAL;
    logic [WIDTH-1:0] RESULT;
    logic             SIG_B;

    modport master (
        output OPCODE, RS_VAL, RT_VAL, SHAMT, FUNC, RAW_VAL,
        input  RESULT, SIG_B
    );

    modport slave (
        input  OPCODE, RS_VAL, RT_VAL, SHAMT, FUNC, RAW_VAL,
        output RESULT, SIG_B
    );
endinterface

// File: rtl/mips_alu.sv
// mips_alu
//   MIPS-style ALU with registered outputs. Decodes OPCODE/FUNC, computes
//   the result from the register operands, shift amount and 16-bit
//   immediate, and flags taken branches. Fixed one-cycle latency, a new
//   operation every cycle.
//
//   Ports:
//     CLK    rising-edge clock
//     RST_N  asynchronous active-low reset; clears RESULT and SIG_B
//     bus    mips_alu_if.slave - operand inputs and registered outputs
module mips_alu #(
    parameter int WIDTH = 32
) (
    input  logic       CLK,
    input  logic       RST_N,
    mips_alu_if.slave  bus
);
    // R-type function codes
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BLEZ  = 6'b000110;
    localparam logic [5:0] OP_BGTZ  = 6'b000111;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    logic [WIDTH-1:0] rs;
    logic [WIDTH-1:0] rt;
    logic [WIDTH-1:0] sext;
    logic [WIDTH-1:0] zext;
    logic [WIDTH-1:0] diff;
    logic [4:0]       var_amt;
    logic             rs_zero;
    logic             rs_neg;

    logic [WIDTH-1:0] next_result;
    logic             next_sig_b;

    assign rs      = bus.RS_VAL;
    assign rt      = bus.RT_VAL;
    assign sext    = {{(WIDTH-16){bus.RAW_VAL[15]}}, bus.RAW_VAL};
    assign zext    = {{(WIDTH-16){1'b0}}, bus.RAW_VAL};
    assign diff    = rs - rt;
    // Variable shifts only honour the low five bits of rs.
    assign var_amt = rs[4:0];
    assign rs_zero = (rs == '0);
    assign rs_neg  = rs[WIDTH-1];

    always_comb begin
        next_result = '0;
        next_sig_b  = 1'b0;
        unique case (bus.OPCODE)
            OP_RTYPE: begin
                unique case (bus.FUNC)
                    FN_ADD, FN_ADDU: next_result = rs + rt;
                    FN_SUB, FN_SUBU: next_result = diff;
                    FN_AND:          next_result = rs & rt;
                    FN_OR:           next_result = rs | rt;
                    FN_XOR:          next_result = rs ^ rt;
                    FN_NOR:          next_result = ~(rs | rt);
                    FN_SLT:          next_result = {{(WIDTH-1){1'b0}}, ($signed(rs) < $signed(rt))};
                    FN_SLTU:         next_result = {{(WIDTH-1){1'b0}}, (rs < rt)};
                    FN_SLL:          next_result = rt << bus.SHAMT;
                    FN_SRL:          next_result = rt >> bus.SHAMT;
                    FN_SRA:          next_result = $unsigned($signed(rt) >>> bus.SHAMT);
                    FN_SLLV:         next_result = rt << var_amt;
                    FN_SRLV:         next_result = rt >> var_amt;
                    FN_SRAV:         next_result = $unsigned($signed(rt) >>> var_amt);
                    default:         next_result = '0;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_LW, OP_SW:
                next_result = rs + sext;
            OP_SLTI:  next_result = {{(WIDTH-1){1'b0}}, ($signed(rs) < $signed(sext))};
            OP_SLTIU: next_result = {{(WIDTH-1){1'b0}}, (rs < sext)};
            OP_ANDI:  next_result = rs & zext;
            OP_ORI:   next_result = rs | zext;
            OP_XORI:  next_result = rs ^ zext;
            OP_LUI:   next_result = {bus.RAW_VAL, {(WIDTH-16){1'b0}}};
            // All branches report rs - rt; only the taken condition differs.
            OP_BEQ: begin
                next_result = diff;
                next_sig_b  = (rs == rt);
            end
            OP_BNE: begin
                next_result = diff;
                next_sig_b  = (rs != rt);
            end
            OP_BLEZ: begin
                next_result = diff;
                next_sig_b  = rs_neg | rs_zero;
            end
            OP_BGTZ: begin
                next_result = diff;
                next_sig_b  = ~rs_neg & ~rs_zero;
            end
            default: begin
                next_result = '0;
                next_sig_b  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bus.RESULT <= '0;
            bus.SIG_B  <= 1'b0;
        end else begin
            bus.RESULT <= next_result;
            bus.SIG_B  <= next_sig_b;
        end
    end
endmodule

// File: tb/tb_mips_alu.sv
module tb_mips_alu;
  logic clk;
  logic rst_n;

  mips_alu_if #(.WIDTH(32)) bus ();

  mips_alu #(.WIDTH(32)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- vector table type ----------------
  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [4:0]  sh;
    logic [5:0]  fn;
    logic [15:0] raw;
    logic [31:0] exp_res;
    logic        exp_b;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic [5:0] op, logic [31:0] rs, logic [31:0] rt,
                              logic [4:0] sh, logic [5:0] fn, logic [15:0] raw,
                              logic [31:0] exp_res, logic exp_b);
    vec_t v;
    v.name = name; v.op = op; v.rs = rs; v.rt = rt; v.sh = sh; v.fn = fn; v.raw = raw;
    v.exp_res = exp_res; v.exp_b = exp_b;
    return v;
  endfunction

  // ---------------- checking ----------------
  task automatic check32(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic check1(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(logic [5:0] op, logic [31:0] rs, logic [31:0] rt,
                       logic [4:0] sh, logic [5:0] fn, logic [15:0] raw);
    @(negedge clk);
    bus.OPCODE  = op;
    bus.RS_VAL  = rs;
    bus.RT_VAL  = rt;
    bus.SHAMT   = sh;
    bus.FUNC    = fn;
    bus.RAW_VAL = raw;
  endtask

  // Drive one operation, let one rising edge capture it, sample 1 time unit later.
  task automatic apply(logic [5:0] op, logic [31:0] rs, logic [31:0] rt,
                       logic [4:0] sh, logic [5:0] fn, logic [15:0] raw);
    drive(op, rs, rt, sh, fn, raw);
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // Works on plain integers: operands become signed/unsigned numbers,
  // shifts become multiplication/division by powers of two, and the
  // result is reduced modulo 2^32 at the end.
  function automatic logic [32:0] ref_model(logic [5:0] op, logic [31:0] rs, logic [31:0] rt,
                                            logic [4:0] sh, logic [5:0] fn, logic [15:0] raw);
    longint two32 = 64'sh1_0000_0000;
    longint urs = longint'({32'd0, rs});
    longint urt = longint'({32'd0, rt});
    longint srs = rs[31] ? urs - two32 : urs;
    longint srt = rt[31] ? urt - two32 : urt;
    longint sext = raw[15] ? longint'({48'd0, raw}) - 65536 : longint'({48'd0, raw});
    longint usext = sext < 0 ? sext + two32 : sext;
    longint zext = longint'({48'd0, raw});
    longint r = 0;
    longint pw = 1;
    bit b = 0;
    int amt;
    logic [63:0] rbits;
    case (int'(op))
      0: begin
        amt = (int'(fn) >= 4 && int'(fn) <= 7) ? int'(urs % 32) : int'(sh);
        for (int i = 0; i < amt; i++) pw = pw * 2;
        case (int'(fn))
          32, 33: r = urs + urt;
          34, 35: r = urs - urt;
          36: r = longint'({32'd0, rs & rt});
          37: r = longint'({32'd0, rs | rt});
          38: r = longint'({32'd0, rs ^ rt});
          39: r = longint'({32'd0, ~(rs | rt)});
          42: r = (srs < srt) ? 1 : 0;
          43: r = (urs < urt) ? 1 : 0;
          0, 4: r = urt * pw;
          2, 6: r = urt / pw;
          3, 7: r = (srt < 0) ? -((-srt + pw - 1) / pw) : srt / pw; // floor division
          default: r = 0;
        endcase
      end
      8, 9, 35, 43: r = urs + sext;
      10: r = (srs < sext) ? 1 : 0;
      11: r = (urs < usext) ? 1 : 0;
      12: r = longint'({32'd0, rs & raw_to32(raw)});
      13: r = longint'({32'd0, rs | raw_to32(raw)});
      14: r = longint'({32'd0, rs ^ raw_to32(raw)});
      15: r = zext * 65536;
      4: begin r = urs - urt; b = (urs == urt); end
      5: begin r = urs - urt; b = (urs != urt); end
      6: begin r = urs - urt; b = (srs <= 0); end
      7: begin r = urs - urt; b = (srs > 0); end
      default: begin r = 0; b = 0; end
    endcase
    rbits = r;
    return {b, rbits[31:0]};
  endfunction

  function automatic logic [31:0] raw_to32(logic [15:0] raw);
    return {16'd0, raw};
  endfunction

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q[$];

  logic [5:0] op_pool[16];
  logic [5:0] fn_pool[17];

  initial begin
    logic [32:0] exp_v;
    logic [31:0] rs, rt;
    logic [5:0]  op, fn;
    logic [4:0]  sh;
    logic [15:0] raw;

    bus.OPCODE = '0; bus.RS_VAL = '0; bus.RT_VAL = '0;
    bus.SHAMT = '0; bus.FUNC = '0; bus.RAW_VAL = '0;
    rst_n = 1'b0;
    #12;
    check32("reset_result", bus.RESULT, 32'h0);
    check1("reset_sig_b", bus.SIG_B, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---------- directed table ----------
    vecs.push_back(mk("bne_15_12",   6'b000101, 32'd15, 32'd12, 5'd0, 6'd0, 16'h0, 32'd3, 1'b1));
    vecs.push_back(mk("bne_15_15",   6'b000101, 32'd15, 32'd15, 5'd0, 6'd0, 16'h0, 32'd0, 1'b0));
    vecs.push_back(mk("bne_5_15",    6'b000101, 32'd5,  32'd15, 5'd0, 6'd0, 16'h0, 32'hFFFFFFF6, 1'b1));
    vecs.push_back(mk("beq_7_7",     6'b000100, 32'd7,  32'd7,  5'd0, 6'd0, 16'h0, 32'd0, 1'b1));
    vecs.push_back(mk("blez_neg1",   6'b000110, 32'hFFFFFFFF, 32'd0, 5'd0, 6'd0, 16'h0, 32'hFFFFFFFF, 1'b1));
    vecs.push_back(mk("blez_zero",   6'b000110, 32'd0, 32'd0, 5'd0, 6'd0, 16'h0, 32'd0, 1'b1));
    vecs.push_back(mk("bgtz_zero",   6'b000111, 32'd0, 32'd0, 5'd0, 6'd0, 16'h0, 32'd0, 1'b0));
    vecs.push_back(mk("bgtz_one",    6'b000111, 32'd1, 32'd0, 5'd0, 6'd0, 16'h0, 32'd1, 1'b1));
    vecs.push_back(mk("add_wrap",    6'b000000, 32'hFFFFFFFF, 32'd1, 5'd0, 6'b100000, 16'h0, 32'd0, 1'b0));
    vecs.push_back(mk("sub_neg",     6'b000000, 32'd5, 32'd15, 5'd0, 6'b100010, 16'h0, 32'hFFFFFFF6, 1'b0));
    vecs.push_back(mk("slt_signed",  6'b000000, 32'hFFFFFFFF, 32'd1, 5'd0, 6'b101010, 16'h0, 32'd1, 1'b0));
    vecs.push_back(mk("sltu_unsig",  6'b000000, 32'hFFFFFFFF, 32'd1, 5'd0, 6'b101011, 16'h0, 32'd0, 1'b0));
    vecs.push_back(mk("sra_4",       6'b000000, 32'd0, 32'h80000000, 5'd4, 6'b000011, 16'h0, 32'hF8000000, 1'b0));
    vecs.push_back(mk("srl_4",       6'b000000, 32'd0, 32'h80000000, 5'd4, 6'b000010, 16'h0, 32'h08000000, 1'b0));
    vecs.push_back(mk("sllv_33",     6'b000000, 32'd33, 32'd1, 5'd0, 6'b000100, 16'h0, 32'd2, 1'b0));
    vecs.push_back(mk("srav_36",     6'b000000, 32'd36, 32'h80000000, 5'd0, 6'b000111, 16'h0, 32'hF8000000, 1'b0));
    vecs.push_back(mk("nor_zero",    6'b000000, 32'd0, 32'd0, 5'd0, 6'b100111, 16'h0, 32'hFFFFFFFF, 1'b0));
    vecs.push_back(mk("rtype_bad",   6'b000000, 32'd9, 32'd3, 5'd1, 6'b000001, 16'h0, 32'd0, 1'b0));
    vecs.push_back(mk("addi_neg",    6'b001000, 32'd10, 32'd0, 5'd0, 6'd0, 16'hFFFF, 32'd9, 1'b0));
    vecs.push_back(mk("ori_zext",    6'b001101, 32'd0, 32'd0, 5'd0, 6'd0, 16'hFFFF, 32'h0000FFFF, 1'b0));
    vecs.push_back(mk("andi_zext",   6'b001100, 32'hFFFFFFFF, 32'd0, 5'd0, 6'd0, 16'h8001, 32'h00008001, 1'b0));
    vecs.push_back(mk("slti_neg",    6'b001010, 32'd5, 32'd0, 5'd0, 6'd0, 16'hFFFF, 32'd0, 1'b0));
    vecs.push_back(mk("sltiu_big",   6'b001011, 32'd5, 32'd0, 5'd0, 6'd0, 16'hFFFF, 32'd1, 1'b0));
    vecs.push_back(mk("lui",         6'b001111, 32'd7, 32'd0, 5'd0, 6'd0, 16'h1234, 32'h12340000, 1'b0));
    vecs.push_back(mk("lw_ea",       6'b100011, 32'd100, 32'd0, 5'd0, 6'd0, 16'h8000, 32'hFFFF8064, 1'b0));
    vecs.push_back(mk("unknown_op",  6'b111111, 32'd5, 32'd5, 5'd3, 6'b100000, 16'h1, 32'd0, 1'b0));

    foreach (vecs[i]) begin
      apply(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].sh, vecs[i].fn, vecs[i].raw);
      check32({vecs[i].name, "_result"}, bus.RESULT, vecs[i].exp_res);
      check1({vecs[i].name, "_sig_b"}, bus.SIG_B, vecs[i].exp_b);
    end

    // ---------- hand-written sequence: hold and async reset ----------
    // Inputs held constant: output must stay put across a second edge.
    apply(6'b000101, 32'd20, 32'd4, 5'd0, 6'd0, 16'h0);
    @(posedge clk); #1;
    check32("hold_result", bus.RESULT, 32'd16);
    check1("hold_sig_b", bus.SIG_B, 1'b1);
    // Assert reset away from any edge: outputs clear without a clock.
    #2;
    rst_n = 1'b0;
    #1;
    check32("async_rst_result", bus.RESULT, 32'd0);
    check1("async_rst_sig_b", bus.SIG_B, 1'b0);
    // An edge during reset must not capture.
    @(posedge clk); #1;
    check32("rst_edge_result", bus.RESULT, 32'd0);
    check1("rst_edge_sig_b", bus.SIG_B, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(6'b000000, 32'd40, 32'd2, 5'd0, 6'b100001, 16'h0);
    check32("post_rst_add", bus.RESULT, 32'd42);
    check1("post_rst_sig_b", bus.SIG_B, 1'b0);

    // ---------- randomized against the reference model ----------
    op_pool = '{6'd0, 6'd0, 6'd0, 6'd8, 6'd9, 6'd10, 6'd11, 6'd12,
                6'd13, 6'd14, 6'd15, 6'd35, 6'd43, 6'd4, 6'd5, 6'd6};
    fn_pool = '{6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38, 6'd39, 6'd42,
                6'd43, 6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7, 6'd1};
    for (int n = 0; n < 400; n++) begin
      op  = (n % 10 == 9) ? 6'($urandom_range(0, 63)) : op_pool[$urandom_range(0, 15)];
      if (n % 7 == 3) op = 6'd7;
      fn  = (n % 11 == 5) ? 6'($urandom_range(0, 63)) : fn_pool[$urandom_range(0, 16)];
      case ($urandom_range(0, 3))
        0: rs = $urandom_range(0, 40);
        1: rs = 32'hFFFFFFFF - $urandom_range(0, 40);
        default: rs = $urandom;
      endcase
      rt  = ($urandom_range(0, 4) == 0) ? rs : $urandom;
      sh  = 5'($urandom_range(0, 31));
      raw = 16'($urandom_range(0, 65535));
      exp_q.push_back(ref_model(op, rs, rt, sh, fn, raw));
      apply(op, rs, rt, sh, fn, raw);
      exp_v = exp_q.pop_front();
      check32("rand_result", bus.RESULT, exp_v[31:0]);
      check1("rand_sig_b", bus.SIG_B, exp_v[32]);
    end

    // ---------- report ----------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
